// File: rtl/butterfly_p2s.sv
// rtl/butterfly_p2s.sv - parallel-to-serial converter emitting lanes in rotated butterfly order
//
// Purpose:
//   Takes one num_output-word parallel beat at a time and emits its words one per cycle.
//   The serial position pos selects the lane (pos mod N + popcount of the next 8 pos bits)
//   mod N, so this stage is the exact inverse of the butterfly serial-to-parallel stage.
//
// Ports:
//   clk      clock, all logic on posedge
//   rst      synchronous active-high reset
//   up_dat   parallel beat, lane i at bits [data_width*i +: data_width]
//   up_vld   parallel beat valid
//   up_rdy   ready for a parallel beat (combinational from dn_rdy while draining)
//   length   serial words per vector, sampled at the first beat of a vector
//   dn_dat   serial word
//   dn_vld   serial word valid
//   dn_rdy   downstream ready
//   dn_last  final word of a vector

module butterfly_p2s #(
    parameter int data_width = 16,
    parameter int num_output = 8
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [num_output*data_width-1:0]   up_dat,
    input  logic                               up_vld,
    output logic                               up_rdy,
    input  logic [15:0]                        length,
    output logic [data_width-1:0]              dn_dat,
    output logic                               dn_vld,
    input  logic                               dn_rdy,
    output logic                               dn_last
);

    localparam int lane_bits = $clog2(num_output);

    typedef enum logic {
        st_empty = 1'b0,
        st_busy  = 1'b1
    } state_t;

    state_t                 state_q;
    state_t                 state_d;

    logic [15:0]            pos_q;
    logic [15:0]            pos_next;
    logic [15:0]            length_q;
    logic [data_width-1:0]  lane_q [num_output];

    logic                   beat_accept;
    logic                   word_accept;
    logic                   beat_end;
    logic                   vec_end;
    logic [lane_bits+3:0]   lane_sum;
    logic [lane_bits-1:0]   lane_sel;

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] c;
        c = 4'd0;
        for (int i = 0; i < 8; i++) begin
            c = c + {3'b000, v[i]};
        end
        return c;
    endfunction

    // Word position inside the current beat and inside the current vector.
    assign beat_end = (pos_q[lane_bits-1:0] == {lane_bits{1'b1}});
    assign vec_end  = (pos_q == length_q - 16'd1);

    // Rotation by the popcount of the beat index keeps the lane order matched to the s2p stage;
    // the sum is truncated to lane_bits, giving the mod-N wrap.
    assign lane_sum = {4'b0000, pos_q[lane_bits-1:0]}
                    + {{lane_bits{1'b0}}, popcount8(pos_q[lane_bits+7:lane_bits])};
    assign lane_sel = lane_sum[lane_bits-1:0];

    assign beat_accept = up_vld & up_rdy;
    assign word_accept = dn_vld & dn_rdy;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= st_empty;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            st_empty: begin
                if (beat_accept) begin
                    state_d = st_busy;
                end
            end
            st_busy: begin
                // The last word of a beat leaves only if no new beat arrives alongside it.
                if (word_accept && beat_end) begin
                    state_d = beat_accept ? st_busy : st_empty;
                end
            end
            default: state_d = st_empty;
        endcase
    end

    // Output logic; both handshake outputs are held low while rst is asserted.
    always_comb begin
        up_rdy = 1'b0;
        dn_vld = 1'b0;
        if (!rst) begin
            case (state_q)
                st_empty: begin
                    up_rdy = 1'b1;
                end
                st_busy: begin
                    dn_vld = 1'b1;
                    up_rdy = dn_rdy & beat_end;
                end
                default: begin
                    up_rdy = 1'b0;
                    dn_vld = 1'b0;
                end
            endcase
        end
    end

    // Serial position after this cycle; wraps to 0 at the final word of a vector.
    always_comb begin
        pos_next = pos_q;
        if (word_accept) begin
            pos_next = vec_end ? 16'd0 : pos_q + 16'd1;
        end
    end

    // Datapath: position counter, vector length and the beat buffer.
    always_ff @(posedge clk) begin
        if (rst) begin
            pos_q    <= 16'd0;
            length_q <= 16'd0;
            for (int i = 0; i < num_output; i++) begin
                lane_q[i] <= '0;
            end
        end else begin
            pos_q <= pos_next;
            if (beat_accept) begin
                for (int i = 0; i < num_output; i++) begin
                    lane_q[i] <= up_dat[data_width*i +: data_width];
                end
                // A beat whose first word lands on position 0 opens a new vector.
                if (pos_next == 16'd0) begin
                    length_q <= length;
                end
            end
        end
    end

    assign dn_dat  = lane_q[lane_sel];
    assign dn_last = dn_vld & vec_end;

endmodule

// File: tb/tb_butterfly_p2s.sv
// tb/tb_butterfly_p2s.sv - self-checking bench for butterfly_p2s
module tb_butterfly_p2s;

    localparam int W = 16;
    localparam int N = 8;

    typedef struct packed {
        logic [W-1:0] dat;
        logic         last;
    } word_t;

    logic           clk = 1'b0;
    logic           rst;
    logic [N*W-1:0] up_dat;
    logic           up_vld;
    logic           up_rdy;
    logic [15:0]    length;
    logic [W-1:0]   dn_dat;
    logic           dn_vld;
    logic           dn_rdy;
    logic           dn_last;

    always #5 clk = ~clk;

    butterfly_p2s #(.data_width(W), .num_output(N)) dut (
        .clk     (clk),
        .rst     (rst),
        .up_dat  (up_dat),
        .up_vld  (up_vld),
        .up_rdy  (up_rdy),
        .length  (length),
        .dn_dat  (dn_dat),
        .dn_vld  (dn_vld),
        .dn_rdy  (dn_rdy),
        .dn_last (dn_last)
    );

    int nerr = 0;
    int nchk = 0;

    word_t          exp_q[$];
    logic [N*W-1:0] beat_q[$];
    logic [W-1:0]   obs_dat[$];
    logic           obs_last[$];
    int             obs_cyc[$];
    int             ncyc      = 0;
    int             beat_cyc  = 0;
    int             rdy_mode  = 0;
    int             mpos      = 0;
    int             mlen      = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Lane holding serial position p: rotate by popcount of the 8-bit beat index.
    function automatic int lane_of(input int p);
        int         hi;
        logic [7:0] h8;
        hi = (p / N) % 256;
        h8 = hi[7:0];
        return ((p % N) + $countones(h8)) % N;
    endfunction

    function automatic logic [N*W-1:0] mk_beat(input int base);
        logic [N*W-1:0] b;
        for (int i = 0; i < N; i++) begin
            b[W*i +: W] = W'(base + i);
        end
        return b;
    endfunction

    task automatic clear_obs();
        obs_dat.delete();
        obs_last.delete();
        obs_cyc.delete();
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while ((beat_q.size() != 0 || exp_q.size() != 0 || up_vld || dn_vld) && n < budget) begin
            @(posedge clk);
            #2;
            n++;
        end
        chk("drain_timeout", (n >= budget), 1'b0);
        repeat (2) @(posedge clk);
        #2;
    endtask

    // Reference model and per-cycle compare.
    initial begin
        word_t          w;
        logic [N*W-1:0] b;
        int             p;
        forever begin
            @(negedge clk);
            ncyc++;
            if (rst) begin
                chk("rst_up_rdy", up_rdy, 1'b0);
                chk("rst_dn_vld", dn_vld, 1'b0);
                chk("rst_dn_last", dn_last, 1'b0);
                exp_q.delete();
                mpos = 0;
                mlen = 0;
            end else begin
                chk("dn_vld", dn_vld, exp_q.size() != 0);
                chk("up_rdy", up_rdy, (exp_q.size() == 0) || (exp_q.size() == 1 && dn_rdy));
                if (exp_q.size() != 0) begin
                    // Head of the model queue is what must be on the bus, stalled or not.
                    chk("dn_dat", dn_dat, exp_q[0].dat);
                    chk("dn_last", dn_last, exp_q[0].last);
                end
                if (dn_vld && dn_rdy && exp_q.size() != 0) begin
                    w = exp_q.pop_front();
                    obs_dat.push_back(dn_dat);
                    obs_last.push_back(dn_last);
                    obs_cyc.push_back(ncyc);
                end
                if (up_vld && up_rdy) begin
                    beat_cyc = ncyc;
                    if (mpos == 0) mlen = int'(length);
                    b = up_dat;
                    for (int j = 0; j < N; j++) begin
                        p = mpos + j;
                        w.dat  = b[W*lane_of(p) +: W];
                        w.last = (p == mlen - 1);
                        exp_q.push_back(w);
                    end
                    mpos = mpos + N;
                    if (mpos >= mlen) mpos = 0;
                end
            end
        end
    end

    // Upstream beat driver and downstream ready pattern.
    initial begin
        int   cyc;
        logic take;
        cyc = 0;
        forever begin
            @(negedge clk);
            take = up_vld && up_rdy;
            @(posedge clk);
            #1;
            if (take && beat_q.size() > 0) beat_q.delete(0);
            up_vld = (beat_q.size() > 0);
            up_dat = up_vld ? beat_q[0] : '0;
            cyc++;
            if (rdy_mode == 0)      dn_rdy = 1'b1;
            else if (rdy_mode == 1) dn_rdy = ((cyc % 2) == 1);
            else                    dn_rdy = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        nerr++;
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $fatal(1);
    end

    initial begin
        logic [N*W-1:0] b4 [32];
        logic [N*W-1:0] tmp;
        logic [W-1:0]   lw;
        int             lanes2 [8];
        int             lanes4 [8];
        int             nlast;
        int             n;

        lanes2 = '{1, 2, 3, 4, 5, 6, 7, 0};
        lanes4 = '{5, 6, 7, 0, 1, 2, 3, 4};

        rst    = 1'b1;
        up_vld = 1'b0;
        up_dat = '0;
        dn_rdy = 1'b1;
        length = 16'd8;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        chk("reset_dn_dat", dn_dat, 16'h0000);
        chk("reset_dn_vld", dn_vld, 1'b0);
        chk("reset_up_rdy", up_rdy, 1'b0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        #1;
        chk("idle_up_rdy", up_rdy, 1'b1);
        chk("idle_dn_vld", dn_vld, 1'b0);

        // 1: one beat, natural order, last on final word, one-cycle latency
        clear_obs();
        length = 16'd8;
        beat_q.push_back(mk_beat(16'h100));
        wait_drain(100);
        chk("t1_count", obs_dat.size(), 8);
        for (int i = 0; i < 8; i++) begin
            chk("t1_dat", obs_dat[i], 16'h100 + i);
            chk("t1_last", obs_last[i], (i == 7));
        end
        chk("t1_latency", obs_cyc[0], beat_cyc + 1);

        // 2: two back-to-back beats, second beat rotated by one
        clear_obs();
        length = 16'd16;
        beat_q.push_back(mk_beat(16'h200));
        beat_q.push_back(mk_beat(16'h210));
        wait_drain(100);
        chk("t2_count", obs_dat.size(), 16);
        chk("t2_no_bubble", obs_cyc[15] - obs_cyc[0], 15);
        for (int i = 0; i < 8; i++) begin
            chk("t2_beat1", obs_dat[i], 16'h200 + i);
            chk("t2_beat2", obs_dat[8+i], 16'h210 + lanes2[i]);
        end
        chk("t2_last", obs_last[15], 1'b1);
        chk("t2_not_last", obs_last[7], 1'b0);

        // 3: alternating backpressure
        clear_obs();
        length   = 16'd8;
        rdy_mode = 1;
        beat_q.push_back(mk_beat(16'h300));
        wait_drain(200);
        rdy_mode = 0;
        chk("t3_count", obs_dat.size(), 8);
        chk("t3_spacing", obs_cyc[7] - obs_cyc[0], 14);
        for (int i = 0; i < 8; i++) begin
            chk("t3_dat", obs_dat[i], 16'h300 + i);
        end

        // 4: 256-word vector of random beats
        clear_obs();
        length = 16'd256;
        for (int b = 0; b < 32; b++) begin
            for (int i = 0; i < N; i++) begin
                b4[b][W*i +: W] = W'($urandom_range(0, 65535));
            end
            beat_q.push_back(b4[b]);
        end
        wait_drain(1000);
        chk("t4_count", obs_dat.size(), 256);
        nlast = 0;
        for (int i = 0; i < obs_last.size(); i++) begin
            if (obs_last[i]) nlast++;
        end
        chk("t4_last_count", nlast, 1);
        chk("t4_last_pos", obs_last[255], 1'b1);
        tmp = b4[31];
        for (int i = 0; i < 8; i++) begin
            lw = tmp[W*lanes4[i] +: W];
            chk("t4_beat31", obs_dat[248+i], lw);
        end

        // 5: reset after three words
        clear_obs();
        length = 16'd8;
        beat_q.push_back(mk_beat(16'h400));
        n = 0;
        while (obs_dat.size() < 3 && n < 50) begin
            @(posedge clk);
            #2;
            n++;
        end
        chk("t5_three_words", obs_dat.size(), 3);
        rst = 1'b1;
        @(negedge clk);
        #1;
        chk("t5_rst_dn_vld", dn_vld, 1'b0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        #1;
        chk("t5_up_rdy", up_rdy, 1'b1);
        chk("t5_dn_vld_idle", dn_vld, 1'b0);
        clear_obs();
        beat_q.push_back(mk_beat(16'h500));
        wait_drain(100);
        chk("t5_count", obs_dat.size(), 8);
        chk("t5_first", obs_dat[0], 16'h500);
        chk("t5_final", obs_dat[7], 16'h507);
        chk("t5_last", obs_last[7], 1'b1);

        // 6: four consecutive 8-word vectors
        clear_obs();
        length = 16'd8;
        for (int b = 0; b < 4; b++) begin
            beat_q.push_back(mk_beat(16'h600 + 16 * b));
        end
        wait_drain(200);
        chk("t6_count", obs_dat.size(), 32);
        for (int i = 0; i < 32; i++) begin
            chk("t6_dat", obs_dat[i], 16'h600 + 16 * (i / 8) + (i % 8));
            chk("t6_last", obs_last[i], ((i % 8) == 7));
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
